// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer with tag-addressed out-of-order writeback.
// Optional macro ROB_EXC_EN adds per-entry exception bits and a self-flush on exceptional commit.
module reorder_buffer #(
    parameter int N_ENTRIES = 8,
    parameter int TAG_W     = $clog2(N_ENTRIES),
    parameter int DATA_W    = 32,
    parameter int REG_W     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef ROB_EXC_EN
    input  logic              wb_exc_i,
    output logic              commit_exc_o,
`endif
    input  logic              alloc_valid_i,
    output logic              alloc_ready_o,
    input  logic [REG_W-1:0]  alloc_rd_i,
    input  logic              alloc_is_store_i,
    output logic [TAG_W-1:0]  alloc_tag_o,
    input  logic              wb_valid_i,
    input  logic [TAG_W-1:0]  wb_tag_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              commit_valid_o,
    input  logic              commit_ready_i,
    output logic [TAG_W-1:0]  commit_tag_o,
    output logic [REG_W-1:0]  commit_rd_o,
    output logic [DATA_W-1:0] commit_data_o,
    output logic              commit_is_store_o,
    input  logic              flush_i,
    output logic [TAG_W:0]    count_o,
    output logic              empty_o,
    output logic              full_o
);
    logic [TAG_W:0]        r_head, r_tail;
    logic [N_ENTRIES-1:0]  r_valid, r_done, r_store;
    logic [REG_W-1:0]      r_rd   [N_ENTRIES];
    logic [DATA_W-1:0]     r_data [N_ENTRIES];
    logic [TAG_W-1:0]      w_hidx, w_tidx;
    logic                  w_alloc, w_commit, w_wb, w_exc_commit, w_flush;

    assign w_hidx  = r_head[TAG_W-1:0];
    assign w_tidx  = r_tail[TAG_W-1:0];
    assign empty_o = r_head == r_tail;
    assign full_o  = (w_hidx == w_tidx) && (r_head[TAG_W] != r_tail[TAG_W]);
    assign count_o = r_tail - r_head;

    assign alloc_ready_o     = !full_o;
    assign alloc_tag_o       = w_tidx;
    assign commit_valid_o    = r_valid[w_hidx] && r_done[w_hidx];
    assign commit_tag_o      = w_hidx;
    assign commit_rd_o       = r_rd[w_hidx];
    assign commit_data_o     = r_data[w_hidx];
    assign commit_is_store_o = r_store[w_hidx];

    assign w_alloc  = alloc_valid_i && alloc_ready_o;
    assign w_commit = commit_valid_o && commit_ready_i;
    assign w_wb     = wb_valid_i && r_valid[wb_tag_i];

`ifdef ROB_EXC_EN
    logic [N_ENTRIES-1:0] r_exc;
    assign commit_exc_o = commit_valid_o && r_exc[w_hidx];
    assign w_exc_commit = w_commit && r_exc[w_hidx];
    always_ff @(posedge clk) begin
        if (w_wb)
            r_exc[wb_tag_i] <= wb_exc_i;
        if (w_alloc)
            r_exc[w_tidx] <= 1'b0;
    end
`else
    assign w_exc_commit = 1'b0;
`endif

    // An exceptional commit retires the head and discards everything younger on the same edge.
    assign w_flush = flush_i || w_exc_commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_valid <= '0;
            r_done  <= '0;
        end else if (w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_valid <= '0;
            r_done  <= '0;
        end else begin
            if (w_wb)
                r_done[wb_tag_i] <= 1'b1;
            // Commit clears done after the writeback so a same-cycle head writeback cannot leak.
            if (w_commit) begin
                r_valid[w_hidx] <= 1'b0;
                r_done[w_hidx]  <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_alloc) begin
                r_valid[w_tidx] <= 1'b1;
                r_done[w_tidx]  <= 1'b0;
                r_tail          <= r_tail + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wb)
            r_data[wb_tag_i] <= wb_data_i;
        if (w_alloc) begin
            r_rd[w_tidx]    <= alloc_rd_i;
            r_store[w_tidx] <= alloc_is_store_i;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed self-checking bench for reorder_buffer (N_ENTRIES=8).
module tb_reorder_buffer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc_valid, alloc_is_store, wb_valid, commit_ready, flush;
    logic [4:0]  alloc_rd;
    logic [2:0]  wb_tag;
    logic [31:0] wb_data;
    logic        alloc_ready, commit_valid, commit_is_store, empty, full;
    logic [2:0]  alloc_tag, commit_tag;
    logic [4:0]  commit_rd;
    logic [31:0] commit_data;
    logic [3:0]  count;
`ifdef ROB_EXC_EN
    logic        wb_exc, commit_exc;
`endif
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reorder_buffer #(.N_ENTRIES(8), .DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef ROB_EXC_EN
        .wb_exc_i(wb_exc), .commit_exc_o(commit_exc),
`endif
        .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready), .alloc_rd_i(alloc_rd),
        .alloc_is_store_i(alloc_is_store), .alloc_tag_o(alloc_tag),
        .wb_valid_i(wb_valid), .wb_tag_i(wb_tag), .wb_data_i(wb_data),
        .commit_valid_o(commit_valid), .commit_ready_i(commit_ready), .commit_tag_o(commit_tag),
        .commit_rd_o(commit_rd), .commit_data_o(commit_data), .commit_is_store_o(commit_is_store),
        .flush_i(flush), .count_o(count), .empty_o(empty), .full_o(full)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        alloc_valid = 0; alloc_rd = 0; alloc_is_store = 0;
        wb_valid = 0; wb_tag = 0; wb_data = 0;
        commit_ready = 0; flush = 0;
`ifdef ROB_EXC_EN
        wb_exc = 0;
`endif
    endtask

    task automatic do_reset;
        idle();
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset;
        do_reset();
        n_cmp++;
        if ({count, empty, full, alloc_ready, commit_valid, alloc_tag} !== {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL reset_state: got cnt=%0d e=%b f=%b rdy=%b cv=%b tag=%0d want 0 1 0 1 0 0",
                     count, empty, full, alloc_ready, commit_valid, alloc_tag);
        end
        alloc_valid = 1;
        repeat (3) tick();
        idle();
        wb_valid = 1; wb_tag = 0; wb_data = 32'h77;
        tick();
        idle();
        n_cmp++;
        if (count !== 4'd3 || commit_valid !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_traffic: got cnt=%0d cv=%b want 3 1", count, commit_valid);
        end
        #2 rst_n = 0;
        #1;
        n_cmp++;
        if ({count, empty, alloc_ready, commit_valid} !== {4'd0, 1'b1, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL async_reset: got cnt=%0d e=%b rdy=%b cv=%b want 0 1 1 0",
                     count, empty, alloc_ready, commit_valid);
        end
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_fill;
        do_reset();
        alloc_valid = 1;
        for (int i = 0; i < 9; i++) begin
            alloc_rd = 5'(i);
            n_cmp++;
            if (alloc_ready !== (i < 8) || (i < 8 && alloc_tag !== 3'(i))) begin
                n_err++;
                $display("FAIL fill_alloc%0d: got rdy=%b tag=%0d want rdy=%b tag=%0d",
                         i, alloc_ready, alloc_tag, i < 8, i);
            end
            tick();
        end
        alloc_valid = 0;
        n_cmp++;
        if (count !== 4'd8 || full !== 1'b1 || empty !== 1'b0) begin
            n_err++;
            $display("FAIL fill_full: got cnt=%0d f=%b e=%b want 8 1 0", count, full, empty);
        end
        wb_valid = 1; wb_tag = 0; wb_data = 32'hAB;
        tick();
        idle();
        alloc_valid = 1; commit_ready = 1;
        n_cmp++;
        if (commit_valid !== 1'b1 || commit_data !== 32'hAB) begin
            n_err++;
            $display("FAIL full_commit_head: got cv=%b data=%h want 1 000000ab", commit_valid, commit_data);
        end
        tick();
        commit_ready = 0;
        n_cmp++;
        if (count !== 4'd7 || full !== 1'b0) begin
            n_err++;
            $display("FAIL full_alloc_blocked: got cnt=%0d f=%b want 7 0", count, full);
        end
        n_cmp++;
        if (alloc_tag !== 3'd0) begin
            n_err++;
            $display("FAIL wrap_tag: got %0d want 0", alloc_tag);
        end
        tick();
        idle();
        n_cmp++;
        if (count !== 4'd8 || full !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_refill: got cnt=%0d f=%b want 8 1", count, full);
        end
    endtask

    task automatic test_ooo_writeback;
        logic [31:0] exp_d [3] = '{32'h10, 32'h20, 32'h30};
        do_reset();
        alloc_valid = 1;
        for (int i = 0; i < 3; i++) begin
            alloc_rd = 5'(i + 1);
            alloc_is_store = (i == 1);
            tick();
        end
        idle();
        for (int i = 2; i >= 0; i--) begin
            wb_valid = 1; wb_tag = 3'(i); wb_data = exp_d[i];
            tick();
            idle();
            n_cmp++;
            if (commit_valid !== (i == 0)) begin
                n_err++;
                $display("FAIL ooo_cvalid_after_wb%0d: got %b want %b", i, commit_valid, i == 0);
            end
        end
        tick();
        n_cmp++;
        if (commit_valid !== 1'b1 || commit_tag !== 3'd0 || commit_data !== 32'h10) begin
            n_err++;
            $display("FAIL ooo_stall_hold: got cv=%b tag=%0d data=%h want 1 0 00000010",
                     commit_valid, commit_tag, commit_data);
        end
        commit_ready = 1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (commit_valid !== 1'b1 || commit_tag !== 3'(i) || commit_data !== exp_d[i] ||
                commit_rd !== 5'(i + 1) || commit_is_store !== (i == 1)) begin
                n_err++;
                $display("FAIL ooo_commit%0d: got cv=%b tag=%0d data=%h rd=%0d st=%b want 1 %0d %h %0d %b",
                         i, commit_valid, commit_tag, commit_data, commit_rd, commit_is_store,
                         i, exp_d[i], i + 1, i == 1);
            end
            tick();
        end
        idle();
        n_cmp++;
        if (empty !== 1'b1 || commit_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ooo_drained: got e=%b cv=%b want 1 0", empty, commit_valid);
        end
    endtask

    task automatic test_wb_corner;
        do_reset();
        wb_valid = 1; wb_tag = 0; wb_data = 32'hDEAD;
        tick();
        idle();
        alloc_valid = 1;
        tick();
        idle();
        tick();
        n_cmp++;
        if (commit_valid !== 1'b0) begin
            n_err++;
            $display("FAIL wb_invalid_ignored: got cv=%b want 0", commit_valid);
        end
        wb_valid = 1; wb_tag = 0; wb_data = 32'h55;
        tick();
        wb_data = 32'h66;
        tick();
        idle();
        commit_ready = 1; wb_valid = 1; wb_tag = 0; wb_data = 32'hAA;
        n_cmp++;
        if (commit_valid !== 1'b1 || commit_data !== 32'h66) begin
            n_err++;
            $display("FAIL wb_last_wins: got cv=%b data=%h want 1 00000066", commit_valid, commit_data);
        end
        tick();
        idle();
        alloc_valid = 1;
        tick();
        idle();
        n_cmp++;
        if (commit_valid !== 1'b0 || count !== 4'd1 || commit_tag !== 3'd1) begin
            n_err++;
            $display("FAIL wb_at_commit_no_leak: got cv=%b cnt=%0d tag=%0d want 0 1 1",
                     commit_valid, count, commit_tag);
        end
    endtask

    task automatic test_back_to_back;
        int j = 0;
        int bad = 0;
        do_reset();
        commit_ready = 1;
        for (int c = 0; c <= 14; c++) begin
            alloc_valid = (c < 12);
            alloc_rd = 5'(c);
            wb_valid = (c >= 1 && c <= 12);
            wb_tag = 3'((c - 1) % 8);
            wb_data = 32'h100 + 32'(c - 1);
            if (c < 12 && alloc_tag !== 3'(c % 8)) begin
                bad++;
                $display("FAIL b2b_tag%0d: got %0d want %0d", c, alloc_tag, c % 8);
            end
            if (commit_valid) begin
                if (commit_tag !== 3'(j % 8) || commit_data !== 32'h100 + 32'(j) || commit_rd !== 5'(j)) begin
                    bad++;
                    $display("FAIL b2b_commit%0d: got tag=%0d data=%h rd=%0d want %0d %h %0d",
                             j, commit_tag, commit_data, commit_rd, j % 8, 32'h100 + j, j);
                end
                j++;
            end
            if (count > 4'd8) begin
                bad++;
                $display("FAIL b2b_count%0d: got %0d want <=8", c, count);
            end
            tick();
        end
        idle();
        n_cmp++;
        if (bad != 0) n_err++;
        n_cmp++;
        if (j != 12 || empty !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_total: got commits=%0d e=%b want 12 1", j, empty);
        end
    endtask

    task automatic test_flush;
        do_reset();
        alloc_valid = 1;
        repeat (5) tick();
        idle();
        wb_valid = 1; wb_tag = 0; wb_data = 32'h9;
        tick();
        idle();
        n_cmp++;
        if (count !== 4'd5 || commit_valid !== 1'b1) begin
            n_err++;
            $display("FAIL flush_pre: got cnt=%0d cv=%b want 5 1", count, commit_valid);
        end
        flush = 1; alloc_valid = 1; commit_ready = 1; wb_valid = 1; wb_tag = 1; wb_data = 32'h1;
        tick();
        idle();
        n_cmp++;
        if (count !== 4'd0 || empty !== 1'b1 || commit_valid !== 1'b0 || alloc_tag !== 3'd0) begin
            n_err++;
            $display("FAIL flush_post: got cnt=%0d e=%b cv=%b tag=%0d want 0 1 0 0",
                     count, empty, commit_valid, alloc_tag);
        end
        alloc_valid = 1;
        tick();
        idle();
        n_cmp++;
        if (count !== 4'd1 || commit_valid !== 1'b0 || alloc_tag !== 3'd1) begin
            n_err++;
            $display("FAIL flush_realloc: got cnt=%0d cv=%b tag=%0d want 1 0 1", count, commit_valid, alloc_tag);
        end
    endtask

`ifdef ROB_EXC_EN
    task automatic test_exception;
        do_reset();
        alloc_valid = 1;
        repeat (3) tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            wb_valid = 1; wb_tag = 3'(i); wb_data = 32'(i + 1); wb_exc = (i == 1);
            tick();
        end
        idle();
        commit_ready = 1;
        n_cmp++;
        if (commit_valid !== 1'b1 || commit_tag !== 3'd0 || commit_exc !== 1'b0) begin
            n_err++;
            $display("FAIL exc_tag0: got cv=%b tag=%0d exc=%b want 1 0 0", commit_valid, commit_tag, commit_exc);
        end
        tick();
        n_cmp++;
        if (commit_valid !== 1'b1 || commit_tag !== 3'd1 || commit_exc !== 1'b1) begin
            n_err++;
            $display("FAIL exc_tag1: got cv=%b tag=%0d exc=%b want 1 1 1", commit_valid, commit_tag, commit_exc);
        end
        tick();
        idle();
        n_cmp++;
        if (empty !== 1'b1 || count !== 4'd0 || alloc_tag !== 3'd0 || commit_valid !== 1'b0) begin
            n_err++;
            $display("FAIL exc_selfflush: got e=%b cnt=%0d tag=%0d cv=%b want 1 0 0 0",
                     empty, count, alloc_tag, commit_valid);
        end
    endtask
`endif

    initial begin
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        test_reset();
        test_fill();
        test_ooo_writeback();
        test_wb_corner();
        test_back_to_back();
        test_flush();
`ifdef ROB_EXC_EN
        test_exception();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
